t05_histogram: RTL

T05_HISTOGRAM -- requirements
Module: t05_histogram

---
 rtl/t05_histogram.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/t05_histogram.sv
// t05_histogram: byte-stream character histogram kept in external SRAM.
// Each accepted byte triggers a read-modify-write of its count word
// (saturating increment). The EOF byte ends the pass and raises hist_fin.
// Optional macro T05_HIST_CLEAR_EN: zero all 256 count words after reset
// and at the start of every new pass, before accepting input.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   en_state[3:0]             controller state, active when 4'b0001
//   in_valid, in_char[7:0]    input byte stream
//   in_ready                  byte accepted when in_valid && in_ready
//   sram_req, WriteorRead     one-cycle request pulse, 1 = write
//   sram_addr[7:0]            count-word address (character code)
//   sram_wdata, sram_rdata    count words
//   SRAM_finished             SRAM transaction complete
//   total                     characters counted in this pass
//   hist_fin                  pass complete
module t05_histogram #(
    parameter int          COUNT_W  = 32,
    parameter logic [7:0]  EOF_CHAR = 8'h1A
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         en_state,
    input  logic               in_valid,
    input  logic [7:0]         in_char,
    output logic               in_ready,
    input  logic [COUNT_W-1:0] sram_rdata,
    input  logic               SRAM_finished,
    output logic               sram_req,
    output logic               WriteorRead,
    output logic [7:0]         sram_addr,
    output logic [COUNT_W-1:0] sram_wdata,
    output logic [COUNT_W-1:0] total,
    output logic               hist_fin
);

    localparam logic [3:0] ACTIVE = 4'b0001;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] READ   = 3'd1;
    localparam logic [2:0] WAIT_R = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] WAIT_W = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
`ifdef T05_HIST_CLEAR_EN
    localparam logic [2:0] CLEAR      = 3'd6;
    localparam logic [2:0] CLEAR_WAIT = 3'd7;
    localparam logic [2:0] START      = CLEAR;
`else
    localparam logic [2:0] START      = IDLE;
`endif

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [2:0] state;
    logic       active;
    logic       accept;
    logic       is_req;
    logic       is_wr;

    assign active = (en_state == ACTIVE);

    // Outputs decoded from state are gated by rst so they drop
    // immediately, even when the reset state itself would drive them.
    assign in_ready = !rst && (state == IDLE) && active;
    assign accept   = in_valid && in_ready;
    assign hist_fin = !rst && (state == DONE);

`ifdef T05_HIST_CLEAR_EN
    assign is_req = (state == READ) || (state == WRITE) ||
                    (state == CLEAR);
    assign is_wr  = (state == WRITE) || (state == CLEAR);
`else
    assign is_req = (state == READ) || (state == WRITE);
    assign is_wr  = (state == WRITE);
`endif

    assign sram_req    = !rst && is_req;
    assign WriteorRead = !rst && is_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= START;
            sram_addr  <= '0;
            sram_wdata <= '0;
            total      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_char == EOF_CHAR) begin
                            state <= DONE;
                        end else begin
                            sram_addr <= in_char;
                            state     <= READ;
                        end
                    end
                end
                READ: state <= WAIT_R;
                WAIT_R: begin
                    if (SRAM_finished) begin
                        sram_wdata <= (sram_rdata == CNT_MAX) ?
                                      CNT_MAX : sram_rdata + CNT_ONE;
                        state      <= WRITE;
                    end
                end
                WRITE: state <= WAIT_W;
                WAIT_W: begin
                    if (SRAM_finished) begin
                        if (total != CNT_MAX)
                            total <= total + CNT_ONE;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (!active) begin
                        total <= '0;
`ifdef T05_HIST_CLEAR_EN
                        sram_addr  <= '0;
                        sram_wdata <= '0;
                        state      <= CLEAR;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef T05_HIST_CLEAR_EN
                CLEAR: state <= CLEAR_WAIT;
                CLEAR_WAIT: begin
                    if (SRAM_finished) begin
                        if (sram_addr == 8'hFF) begin
                            state <= IDLE;
                        end else begin
                            sram_addr <= sram_addr + 8'd1;
                            state     <= CLEAR;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
